demux_deserializer: RTL and testbench

- Receiver-side counterpart of the 2:1 gate multiplexer: takes one time-multiplexed serial bit stream plus a 1-bit `select` tag.
- Routes each valid bit to one of two channels and assembles WIDTH-bit words per channel.
- Presents each completed word with a held `done` flag, which the consumer clears with an `ack` handshake.
- Sits after the mux stage in the guia07 datapath, reconstructing the two multiplexed sources.

---
 rtl/demux_deserializer_if.sv | 38 +++
 rtl/demux_deserializer.sv | 102 ++++++++++
 tb/tb_demux_deserializer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/demux_deserializer_if.sv
// rtl/demux_deserializer_if.sv - serial-in / two-channel word-out bundle for demux_deserializer
//
// Purpose: groups the serial input, the per-channel acknowledges and the
// per-channel word/flag outputs of the demux deserializer.
// Signals:
//   din, valid, select : serial bit, qualifier, channel tag (0 -> ch0, 1 -> ch1)
//   ack0, ack1         : consumer acknowledge per channel
//   word0, word1       : last completed word per channel
//   done0, done1       : word holds an unacknowledged new value
//   ovf0, ovf1         : sticky, a bit was dropped while the channel was full
// Modports:
//   master : the side that drives the stream and consumes words (bench / upstream)
//   slave  : the deserializer itself
interface demux_deserializer_if #(
   parameter int WIDTH = 4
);
   logic             din;
   logic             valid;
   logic             select;
   logic             ack0;
   logic             ack1;
   logic [WIDTH-1:0] word0;
   logic [WIDTH-1:0] word1;
   logic             done0;
   logic             done1;
   logic             ovf0;
   logic             ovf1;

   modport master (
      output din, valid, select, ack0, ack1,
      input  word0, word1, done0, done1, ovf0, ovf1
   );

   modport slave (
      input  din, valid, select, ack0, ack1,
      output word0, word1, done0, done1, ovf0, ovf1
   );
endinterface

// File: rtl/demux_deserializer.sv
// rtl/demux_deserializer.sv - routes a tagged serial stream into two WIDTH-bit word channels
//
// Purpose: each valid bit goes to the channel named by select, is shifted in
// MSB-first, and the bit completing WIDTH bits publishes the word with a held
// done flag. The consumer clears done with ack. Bits arriving for a channel
// whose done is still set (and not acked that cycle) are dropped and flag ovf.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; clears words, flags, shift registers, counters
//   bus   : demux_deserializer_if.slave (din/valid/select/ack0/ack1 in,
//           word0/word1/done0/done1/ovf0/ovf1 out)
module demux_deserializer #(
   parameter int WIDTH = 4
) (
   input  logic                  clk,
   input  logic                  reset,
   demux_deserializer_if.slave   bus
);
   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

   typedef enum logic {
      COLLECT = 1'b0,
      FULL    = 1'b1
   } state_t;

   logic [1:0]            ack;
   logic [1:0]            done_w;
   logic [1:0]            ovf_w;
   logic [1:0][WIDTH-1:0] word_w;

   assign ack = {bus.ack1, bus.ack0};

   for (genvar c = 0; c < 2; c++) begin : g_ch
      state_t           state_q, state_d;
      logic [WIDTH-1:0] sh_q, sh_d;
      logic [WIDTH-1:0] word_q, word_d;
      logic [CW-1:0]    cnt_q, cnt_d;
      logic             ovf_q, ovf_d;
      logic             hit;
      logic             accept;
      logic [WIDTH-1:0] shifted;

      always_ff @(posedge clk) begin
         if (reset) begin
            state_q <= COLLECT;
            sh_q    <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
         end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            word_q  <= word_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
         end
      end

      always_comb begin
         state_d = state_q;
         sh_d    = sh_q;
         word_d  = word_q;
         cnt_d   = cnt_q;
         ovf_d   = ovf_q;
         hit     = bus.valid && (bus.select == 1'(c));
         // An ack in the same cycle frees the channel, so the bit is taken.
         accept  = hit && ((state_q == COLLECT) || ack[c]);
         shifted = {sh_q[WIDTH-2:0], bus.din};

         if ((state_q == FULL) && ack[c]) begin
            state_d = COLLECT;
         end

         if (hit && !accept) begin
            ovf_d = 1'b1;
         end

         if (accept) begin
            sh_d = shifted;
            if (cnt_q == CW'(WIDTH - 1)) begin
               // Completing bit: publishes the word; overrides a same-cycle ack.
               word_d  = shifted;
               cnt_d   = '0;
               state_d = FULL;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
      end

      assign done_w[c] = (state_q == FULL);
      assign ovf_w[c]  = ovf_q;
      assign word_w[c] = word_q;
   end

   assign bus.word0 = word_w[0];
   assign bus.word1 = word_w[1];
   assign bus.done0 = done_w[0];
   assign bus.done1 = done_w[1];
   assign bus.ovf0  = ovf_w[0];
   assign bus.ovf1  = ovf_w[1];
endmodule

// File: tb/tb_demux_deserializer.sv
// tb/tb_demux_deserializer.sv - directed self-checking bench for demux_deserializer
module tb_demux_deserializer;
   localparam int WIDTH = 4;

   logic clk;
   logic reset;
   int   n_checks;
   int   n_fail;

   demux_deserializer_if #(.WIDTH(WIDTH)) bus ();

   demux_deserializer #(.WIDTH(WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic sel, input logic bit_in);
      bus.valid  = 1'b1;
      bus.select = sel;
      bus.din    = bit_in;
      tick();
      bus.valid  = 1'b0;
   endtask

   task automatic chk_all(input string tag, input logic [3:0] w0, input logic [3:0] w1,
                          input logic d0, input logic d1, input logic o0, input logic o1);
      chk({tag, ".word0"}, 8'(bus.word0), 8'(w0));
      chk({tag, ".word1"}, 8'(bus.word1), 8'(w1));
      chk({tag, ".done0"}, 8'(bus.done0), 8'(d0));
      chk({tag, ".done1"}, 8'(bus.done1), 8'(d1));
      chk({tag, ".ovf0"},  8'(bus.ovf0),  8'(o0));
      chk({tag, ".ovf1"},  8'(bus.ovf1),  8'(o1));
   endtask

   initial begin
      n_checks   = 0;
      n_fail     = 0;
      reset      = 1'b1;
      bus.din    = 1'b0;
      bus.valid  = 1'b0;
      bus.select = 1'b0;
      bus.ack0   = 1'b0;
      bus.ack1   = 1'b0;

      // 1: reset, idle, stray acks
      tick();
      tick();
      chk_all("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      bus.select = 1'b1;
      bus.din    = 1'b1;
      tick();
      chk_all("idle", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      bus.ack0 = 1'b1;
      bus.ack1 = 1'b1;
      tick();
      bus.ack0 = 1'b0;
      bus.ack1 = 1'b0;
      chk_all("stray_ack", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // 2: one ch0 word 1011, then ack
      send(1'b0, 1'b1);
      send(1'b0, 1'b0);
      send(1'b0, 1'b1);
      chk("t2.done0_early", 8'(bus.done0), 8'h0);
      send(1'b0, 1'b1);
      chk_all("t2.word", 4'b1011, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk("t2.done0_held", 8'(bus.done0), 8'h1);
      bus.ack0 = 1'b1;
      tick();
      bus.ack0 = 1'b0;
      chk_all("t2.ack", 4'b1011, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

      // 3: interleaved channels
      send(1'b0, 1'b1);
      send(1'b0, 1'b1);
      send(1'b1, 1'b0);
      send(1'b1, 1'b1);
      send(1'b1, 1'b1);
      send(1'b1, 1'b0);
      chk_all("t3.ch1", 4'b1011, 4'b0110, 1'b0, 1'b1, 1'b0, 1'b0);
      send(1'b0, 1'b0);
      send(1'b0, 1'b0);
      chk_all("t3.ch0", 4'b1100, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b0);
      bus.ack1 = 1'b1;
      tick();
      bus.ack1 = 1'b0;
      chk("t3.ack1", 8'(bus.done1), 8'h0);

      // 4: overflow on ch0, then ack with a new word
      send(1'b0, 1'b1);
      send(1'b0, 1'b1);
      chk_all("t4.ovf", 4'b1100, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b0);
      bus.ack0 = 1'b1;
      send(1'b0, 1'b0);
      bus.ack0 = 1'b0;
      chk("t4.ack_done0", 8'(bus.done0), 8'h0);
      send(1'b0, 1'b1);
      send(1'b0, 1'b0);
      send(1'b0, 1'b1);
      chk_all("t4.word", 4'b0101, 4'b0110, 1'b1, 1'b0, 1'b1, 1'b0);

      // 5: same-cycle ack and accepted bit on ch1
      send(1'b1, 1'b1);
      send(1'b1, 1'b1);
      send(1'b1, 1'b1);
      send(1'b1, 1'b1);
      chk_all("t5.fill", 4'b0101, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      chk_all("t5.drop", 4'b0101, 4'b1111, 1'b1, 1'b1, 1'b1, 1'b1);
      bus.ack1 = 1'b1;
      send(1'b1, 1'b1);
      bus.ack1 = 1'b0;
      chk("t5.ack_done1", 8'(bus.done1), 8'h0);
      send(1'b1, 1'b0);
      send(1'b1, 1'b0);
      chk("t5.done1_early", 8'(bus.done1), 8'h0);
      send(1'b1, 1'b1);
      chk_all("t5.word", 4'b0101, 4'b1001, 1'b1, 1'b1, 1'b1, 1'b1);

      // 6: reset mid-word discards the partial word
      bus.ack0 = 1'b1;
      bus.ack1 = 1'b1;
      tick();
      bus.ack0 = 1'b0;
      bus.ack1 = 1'b0;
      send(1'b0, 1'b1);
      send(1'b0, 1'b0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_all("t6.reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);
      send(1'b0, 1'b1);
      send(1'b0, 1'b1);
      send(1'b0, 1'b1);
      chk("t6.done0_early", 8'(bus.done0), 8'h0);
      send(1'b0, 1'b0);
      chk_all("t6.word", 4'b1110, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
